// File: rtl/pwl_activation_pipe.sv
// rtl/pwl_activation_pipe.sv - LANES-wide 3-stage piecewise-linear activation pipe with saturation counter
// Optional tanh for mode 3 under PWL_ACT_TANH_EN; without it mode 3 evaluates hard-sigmoid.
module pwl_activation_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_mode,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_sat,
    input  logic                        sat_clr,
    output logic [15:0]                 sat_count
);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef enum logic [1:0] {
        MODE_HSIG = 2'd0,
        MODE_PLAN = 2'd1,
        MODE_RELU = 2'd2,
        MODE_TANH = 2'd3
    } mode_e;

    localparam sample_t ONE     = sample_t'(1 << FRACT_WIDTH);
    localparam sample_t TWO     = sample_t'(2 << FRACT_WIDTH);
    localparam sample_t FIVE    = sample_t'(5 << FRACT_WIDTH);
    localparam sample_t K_2P375 = sample_t'(19 << (FRACT_WIDTH - 3));
    localparam sample_t C_HI    = sample_t'(27 << (FRACT_WIDTH - 5));
    localparam sample_t C_MID   = sample_t'(5 << (FRACT_WIDTH - 3));
    localparam sample_t C_LO    = sample_t'(1 << (FRACT_WIDTH - 1));
    localparam sample_t MAX_POS = sample_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam sample_t MIN_NEG = sample_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});
`ifdef PWL_ACT_TANH_EN
    localparam sample_t HALF_MAX = MAX_POS >>> 1;
    localparam sample_t HALF_MIN = MIN_NEG >>> 1;
`endif

    logic        advance;
    logic        ld1, ld2, ld3;
    logic        s1_valid_q, s2_valid_q, s3_valid_q;
    mode_e       s1_mode_d, s1_mode_q, s2_mode_q;
    logic [16:0] sat_sum;
    logic [15:0] sat_count_d, sat_count_q;

    // One global enable: a stalled output freezes every stage, bubbles included.
    assign advance   = !s3_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign sat_count = sat_count_q;
    assign ld1       = advance && in_valid;
    assign ld2       = advance && s1_valid_q;
    assign ld3       = advance && s2_valid_q;

    always_comb begin
        s1_mode_d = mode_e'(in_mode);
`ifndef PWL_ACT_TANH_EN
        if (in_mode == 2'd3) s1_mode_d = MODE_HSIG;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_mode_q  <= MODE_HSIG;
            s2_mode_q  <= MODE_HSIG;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            if (in_valid)   s1_mode_q <= s1_mode_d;
            if (s1_valid_q) s2_mode_q <= s1_mode_q;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sample_t    x_in, x_eff, a_in;
        logic       neg_in, sat_in;
        logic [1:0] seg_in;
        sample_t    s1_x_q, s1_a_q;
        logic       s1_neg_q, s1_sat_q;
        logic [1:0] s1_seg_q;
        sample_t    s2_y_d, s2_y_q;
        logic       s2_neg_q, s2_sat_q;
        sample_t    s3_y_d, s3_y_q;
        logic       s3_sat_q;

        assign x_in = sample_t'(in_data[g*DATA_WIDTH +: DATA_WIDTH]);

        // S1 front end: optional doubling, saturating magnitude, PLAN segment index.
        always_comb begin
            x_eff = x_in;
`ifdef PWL_ACT_TANH_EN
            if (s1_mode_d == MODE_TANH) begin
                if (x_in > HALF_MAX)      x_eff = MAX_POS;
                else if (x_in < HALF_MIN) x_eff = MIN_NEG;
                else                      x_eff = x_in <<< 1;
            end
`endif
            neg_in = x_eff[DATA_WIDTH-1];
            if (!neg_in)                a_in = x_eff;
            else if (x_eff == MIN_NEG)  a_in = MAX_POS;
            else                        a_in = -x_eff;

            if (a_in < ONE)          seg_in = 2'd0;
            else if (a_in < K_2P375) seg_in = 2'd1;
            else if (a_in < FIVE)    seg_in = 2'd2;
            else                     seg_in = 2'd3;

            case (s1_mode_d)
                MODE_HSIG: sat_in = (a_in >= TWO);
                MODE_RELU: sat_in = 1'b0;
                default:   sat_in = (seg_in == 2'd3);
            endcase
        end

        // S2: shift-add on the magnitude; sigmoid sign fold is deferred to S3.
        always_comb begin
            s2_y_d = '0;
            case (s1_mode_q)
                MODE_HSIG: begin
                    if (s1_sat_q) s2_y_d = s1_neg_q ? '0 : ONE;
                    else          s2_y_d = (s1_x_q + TWO) >>> 2;
                end
                MODE_RELU: s2_y_d = s1_neg_q ? '0 : s1_x_q;
                default: begin
                    case (s1_seg_q)
                        2'd0:    s2_y_d = (s1_a_q >>> 2) + C_LO;
                        2'd1:    s2_y_d = (s1_a_q >>> 3) + C_MID;
                        2'd2:    s2_y_d = (s1_a_q >>> 5) + C_HI;
                        default: s2_y_d = ONE;
                    endcase
                end
            endcase
        end

        always_comb begin
            s3_y_d = s2_y_q;
            if (s2_mode_q == MODE_PLAN || s2_mode_q == MODE_TANH) begin
                if (s2_neg_q) s3_y_d = ONE - s2_y_q;
`ifdef PWL_ACT_TANH_EN
                if (s2_mode_q == MODE_TANH) s3_y_d = (s3_y_d <<< 1) - ONE;
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_x_q   <= '0;
                s1_a_q   <= '0;
                s1_neg_q <= 1'b0;
                s1_sat_q <= 1'b0;
                s1_seg_q <= 2'd0;
                s2_y_q   <= '0;
                s2_neg_q <= 1'b0;
                s2_sat_q <= 1'b0;
                s3_y_q   <= '0;
                s3_sat_q <= 1'b0;
            end else begin
                if (ld1) begin
                    s1_x_q   <= x_in;
                    s1_a_q   <= a_in;
                    s1_neg_q <= neg_in;
                    s1_sat_q <= sat_in;
                    s1_seg_q <= seg_in;
                end
                if (ld2) begin
                    s2_y_q   <= s2_y_d;
                    s2_neg_q <= s1_neg_q;
                    s2_sat_q <= s1_sat_q;
                end
                if (ld3) begin
                    s3_y_q   <= s3_y_d;
                    s3_sat_q <= s2_sat_q;
                end
            end
        end

        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = s3_y_q;
        assign out_sat[g]                           = s3_sat_q;
    end

    // A clear coinciding with an output handshake drops that beat's contribution.
    always_comb begin
        sat_sum = {1'b0, sat_count_q};
        for (int i = 0; i < LANES; i++) begin
            sat_sum = sat_sum + 17'(out_sat[i]);
        end
        sat_count_d = sat_count_q;
        if (sat_clr)
            sat_count_d = '0;
        else if (s3_valid_q && out_ready)
            sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) sat_count_q <= '0;
        else       sat_count_q <= sat_count_d;
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// tb/tb_pwl_activation_pipe.sv - self-checking bench for pwl_activation_pipe (DATA_WIDTH 16, FRACT_WIDTH 8, LANES 4)
module tb_pwl_activation_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic [1:0]  in_mode = 2'd0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_sat;
    logic [15:0] sat_count;

    pwl_activation_pipe #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .LANES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  sat;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pop_count = 0;
    int          cnt_m = 0;
    bit          free_run = 1'b1;
    bit          prev_stall = 1'b0;
    bit          bp_done = 1'b0;
    logic [63:0] prev_data, last_data;
    logic [3:0]  prev_sat, last_sat;
    logic [15:0] tbl [8] = '{16'hFE00, 16'h0260, 16'h025F, 16'h0500,
                             16'h8000, 16'h7FFF, 16'hFE80, 16'h0060};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int abs_sat(input int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int plan(input int a);
        if (a >= 1280) return 256;
        if (a >= 608)  return a / 32 + 216;
        if (a >= 256)  return a / 8 + 160;
        return a / 4 + 128;
    endfunction

    function automatic int sig(input int x);
        int p;
        p = plan(abs_sat(x));
        return (x < 0) ? 256 - p : p;
    endfunction

    function automatic void lane_model(input int mode, input logic [15:0] raw,
                                       output logic [15:0] y, output logic sat);
        int x, m, r, x2;
        x = int'($signed(raw));
        m = mode;
`ifndef PWL_ACT_TANH_EN
        if (m == 3) m = 0;
`endif
        case (m)
            0: begin
                sat = abs_sat(x) >= 512;
                if (x <= -512)     r = 0;
                else if (x >= 512) r = 256;
                else               r = (x + 512) / 4;
            end
            1: begin
                sat = abs_sat(x) >= 1280;
                r = sig(x);
            end
            2: begin
                sat = 1'b0;
                r = (x < 0) ? 0 : x;
            end
            default: begin
                x2 = 2 * x;
                if (x2 > 32767)  x2 = 32767;
                if (x2 < -32768) x2 = -32768;
                sat = abs_sat(x2) >= 1280;
                r = 2 * sig(x2) - 256;
            end
        endcase
        y = r[15:0];
    endfunction

    function automatic beat_t beat_model(input int mode, input logic [63:0] d);
        beat_t       b;
        logic [15:0] y;
        logic        s;
        for (int i = 0; i < 4; i++) begin
            lane_model(mode, d[i*16 +: 16], y, s);
            b.data[i*16 +: 16] = y;
            b.sat[i] = s;
        end
        b.cyc = 0;
        return b;
    endfunction

    function automatic logic [63:0] pack(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    always @(negedge clk) begin
        beat_t e;
        int    popc;
        if (reset) begin
            exp_q.delete();
            cnt_m = 0;
            prev_stall = 1'b0;
        end else begin
            popc = 0;
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            check("sat_count", sat_count, cnt_m);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_sat", out_sat, prev_sat);
            end
            if (in_valid && in_ready) begin
                e = beat_model(in_mode, in_data);
                e.cyc = cyc;
                exp_q.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sat", out_sat, e.sat);
                    if (free_run) check("latency", cyc - e.cyc, 3);
                    popc = $countones(e.sat);
                    pop_count++;
                    last_data = out_data;
                    last_sat = out_sat;
                end
            end
            if (sat_clr) cnt_m = 0;
            else if (out_valid && out_ready) cnt_m = (cnt_m + popc > 65535) ? 65535 : cnt_m + popc;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_sat = out_sat;
        end
    end

    task automatic send(input int mode, input logic [63:0] d);
        int n;
        n = 0;
        in_mode = mode[1:0];
        in_data = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check("send_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pop_count < target && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("pop_timeout", pop_count >= target, 1);
    endtask

    initial begin
        logic [15:0] y;
        logic        s;
        int          base, n;

        lane_model(1, 16'h0400, y, s);
        check("model_plan_4p0", {y, 3'b0, s}, {16'h00F8, 4'b0000});
        lane_model(1, 16'h0260, y, s);
        check("model_plan_2p375", {y, 3'b0, s}, {16'h00EB, 4'b0000});
        lane_model(0, 16'hFE00, y, s);
        check("model_hsig_m2", {y, 3'b0, s}, {16'h0000, 4'b0001});
        lane_model(2, 16'h8000, y, s);
        check("model_relu_min", {y, 3'b0, s}, {16'h0000, 4'b0000});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);

        send(0, pack(16'h0000, 16'h0100, 16'hFF00, 16'h0300));
        wait_pops(1);
        check("t_hsig_data", last_data, pack(16'h0080, 16'h00C0, 16'h0040, 16'h0100));
        check("t_hsig_sat", last_sat, 4'b1000);

        @(posedge clk);
        #1 sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        check("clr_idle", sat_count, 0);

        send(1, pack(16'h0400, 16'hFC00, 16'h8000, 16'h0080));
        wait_pops(2);
        check("t_plan_data", last_data, pack(16'h00F8, 16'h0008, 16'h0000, 16'h00A0));
        check("t_plan_sat", last_sat, 4'b0100);
        check("t_plan_count", sat_count, 1);

        send(2, pack(16'hFD00, 16'h0180, 16'h0000, 16'h7FFF));
        wait_pops(3);
        check("t_relu_data", last_data, pack(16'h0000, 16'h0180, 16'h0000, 16'h7FFF));
        check("t_relu_sat", last_sat, 4'b0000);

        send(3, pack(16'h0000, 16'h0100, 16'hFF00, 16'h0500));
        wait_pops(4);
`ifdef PWL_ACT_TANH_EN
        check("t_tanh_data", last_data, pack(16'h0000, 16'h00C0, 16'hFF40, 16'h0100));
`else
        check("t_mode3_data", last_data, pack(16'h0080, 16'h00C0, 16'h0040, 16'h0100));
`endif
        check("t_mode3_sat", last_sat, 4'b1000);
        check("t_mode3_count", sat_count, 2);

        for (int i = 0; i < 4; i++) send(i, pack(tbl[i], tbl[i+1], tbl[i+2], tbl[i+3]));
        wait_pops(8);

        free_run = 1'b0;
        base = pop_count;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i % 4, pack(tbl[i], tbl[(i+3)%8], tbl[(i+5)%8], tbl[(i+6)%8]));
                bp_done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while ((!bp_done || exp_q.size() != 0) && g < 400) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                    g++;
                end
                check("bp_drain", exp_q.size(), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("bp_count", pop_count - base, 8);
        free_run = 1'b1;

        base = pop_count;
        for (int i = 0; i < 20000; i++) send(0, pack(16'h0300, 16'hFD00, 16'h7FFF, 16'h8000));
        wait_pops(base + 20000);
        check("cnt_sticky", sat_count, 16'hFFFF);

        send(0, pack(16'h0300, 16'h0300, 16'h0300, 16'h0300));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("clr_wait", out_valid, 1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        check("clr_on_handshake", sat_count, 0);

        in_mode = 2'd1;
        in_data = pack(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        check("rst_mid_valid", out_valid, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("rst_no_stale", out_valid, 0);
        end
        base = pop_count;
        send(2, pack(16'h0123, 16'hF000, 16'h0001, 16'h8000));
        wait_pops(base + 1);
        check("post_rst_data", last_data, pack(16'h0123, 16'h0000, 16'h0001, 16'h0000));

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwl_activation_pipe.md
# pwl_activation_pipe

Multi-lane, pipelined piecewise-linear activation unit for the denoise datapath. It replaces the single-sample combinational sigmoid with a valid/ready-streamed engine. The engine evaluates hard-sigmoid, PLAN-sigmoid or ReLU (tanh optional) on LANES fixed-point samples per beat, and keeps a saturation statistic. It sits between the MAC/accumulator output and the next layer's input buffer.

## Interface
- DATA_WIDTH, 16, total bits per sample, two's complement Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH
- FRACT_WIDTH, 8, fraction bits; legal range 5..DATA_WIDTH-4
- LANES, 4, samples per beat
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_mode  in  2  function select, sampled with each beat: 0 hard-sigmoid, 1 PLAN-sigmoid, 2 ReLU, 3 tanh
- in_data  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*DATA_WIDTH  results, same lane packing, same Q format
- out_sat  out  LANES  per-lane flag, set when the lane's input lay in a clipped region
- sat_clr  in  1  clears sat_count
- sat_count  out  16  saturating count of flagged lanes on accepted output beats

## Operation
- 1.0 = 1<<FRACT_WIDTH. a = |x|; for x = most-negative, a saturates to max positive.
- Mode 0, hard-sigmoid:
  - x <= -2 → 0; x >= 2 → 1.0; else (x+2)>>>2.
  - Sat when a >= 2.
- Mode 1, PLAN-sigmoid, computed on a:
  - a >= 5 → 1.0
  - 2.375 <= a < 5 → a/32 + 0.84375
  - 1 <= a < 5/... i.e. 1 <= a < 2.375 → a/8 + 0.625
  - a < 1 → a/4 + 0.5
  - Shifts truncate. For x < 0, the result is 1.0 − y(a).
  - Sat when a >= 5.
- Mode 2, ReLU: x < 0 → 0, else x. Never sat.
- Mode 3, tanh:
  - Computes 2·PLAN(2x) − 1. 2x saturates to the DATA_WIDTH range before evaluation.
  - Output is signed in [−1.0, 1.0]. Sat when |2x| >= 5.
- Pipeline stages:
  - S1: register the input and compute abs and segment compare.
  - S2: shift-add evaluation.
  - S3: symmetry fold, tanh rescale, output register.
- Mode and valid travel with the beat, so each beat is evaluated in its own mode. Mode changes between beats need no bubble.
- sat_count on each output handshake:
  - Adds popcount(out_sat) and saturates at 0xFFFF.
  - sat_clr in the same cycle wins: count becomes 0 and that beat is not added.

## Timing
- Latency: 3 cycles from input handshake to out_valid, when there is no backpressure. Throughput is 1 beat/cycle.
- in_ready = !s3_valid | out_ready. All stages advance together; a stall freezes the whole pipe.
- Bubbles are not compressed.
- out_data and out_sat stay stable while out_valid & !out_ready.
- Reset values: in_ready 1, out_valid 0, out_data 0, out_sat 0, sat_count 0, and all stage valids cleared.
- Reset asserted mid-stream discards every in-flight beat. The first accepted beat after reset appears 3 cycles after its handshake.
- in_data and in_mode are ignored when in_valid is 0. Downstream must not rely on out_data when out_valid is 0.

## Configuration
- PWL_ACT_TANH_EN defined: mode 3 is tanh as above. This adds the doubling saturator and the 2y−1 rescale in S3.
- PWL_ACT_TANH_EN undefined: mode 3 is decoded as mode 0 (hard-sigmoid). The tanh logic is absent.

## Test plan
All values use DATA_WIDTH=16, FRACT_WIDTH=8, LANES=4.
- Reset, then lanes {0x0000, 0x0100, 0xFF00, 0x0300} in mode 0, out_ready=1 → exactly 3 cycles later out_data {0x0080, 0x00C0, 0x0040, 0x0100}, out_sat 4'b1000.
- Mode 1, lanes {0x0400, 0xFC00, 0x8000, 0x0080} → {0x00F8, 0x0008, 0x0000, 0x00A0}, out_sat 4'b0100; sat_count becomes 1.
- Mode 2, lanes {0xFD00, 0x0180, 0x0000, 0x7FFF} → {0x0000, 0x0180, 0x0000, 0x7FFF}, out_sat 0.
- Mode 3 with PWL_ACT_TANH_EN, lanes {0x0000, 0x0100, 0xFF00, 0x0500} → {0x0000, 0x00C0, 0xFF40, 0x0100}, out_sat 4'b1000. Without the macro, the same stimulus gives mode-0 results.
- Backpressure: stream 8 beats with alternating modes while out_ready toggles pseudo-randomly → no beat is lost or duplicated, and output order and per-beat mode match the input. Outputs hold during stalls, and in_ready drops only when S3 is full and out_ready=0.
- Counter: feed 20000 all-saturating beats → sat_count sticks at 0xFFFF. Then pulse sat_clr in the same cycle as a handshake → sat_count = 0. Assert reset mid-stream → out_valid is 0 the next cycle.
